// File: rtl/lfsr_crc_stream_pkg.sv
// lfsr_crc_stream: shared CRC constants and frame FSM encoding.
// Residue constants are raw (uninverted) reflected register values.
package lfsr_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04c11db7;
  localparam logic [31:0] CRC32C_POLY   = 32'h1edc6f41;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [31:0] CRC32_RESIDUE = 32'hdebb20e3;

  typedef enum logic {
    FRM_IDLE,
    FRM_IN
  } frame_state_e;

endpackage

// File: rtl/lfsr_crc_stream_if.sv
// lfsr_crc_stream: input beat stream and result handshake bundle.
// master drives beats and m_ready; slave is the CRC engine.
interface lfsr_crc_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int LFSR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] s_data;
  logic [KEEP_WIDTH-1:0] s_keep;
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_last;
  logic [LFSR_WIDTH-1:0] m_crc;
  logic [LEN_WIDTH-1:0]  m_len;
  logic                  m_crc_ok;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output s_data, s_keep, s_valid, s_last, m_ready,
    input  s_ready, m_crc, m_len, m_crc_ok, m_valid
  );

  modport slave (
    input  s_data, s_keep, s_valid, s_last, m_ready,
    output s_ready, m_crc, m_len, m_crc_ok, m_valid
  );
endinterface

// File: rtl/lfsr_crc_stream_lanes.sv
// lfsr_crc_stream_lanes: chained per-byte LFSR steps and keep-prefix mux.
// Purely combinational; lane k output covers bytes 0..k.
module lfsr_crc_stream_lanes #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = '1,
  parameter string                 LFSR_CONFIG = "GALOIS",
  parameter bit                    REVERSE     = 1'b1,
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int                    NW          = 4
) (
  input  logic [LFSR_WIDTH-1:0] state_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [KEEP_WIDTH-1:0] keep_i,
  output logic [LFSR_WIDTH-1:0] step_o,
  output logic [NW-1:0]         n_o
);

  localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");

  function automatic logic [LFSR_WIDTH-1:0] byte_step(
    input logic [LFSR_WIDTH-1:0] s,
    input logic [7:0]            d
  );
    logic [LFSR_WIDTH-1:0] r;
    logic b;
    logic fb;
    r = s;
    for (int i = 0; i < 8; i++) begin
      b = REVERSE ? d[i] : d[7-i];
      if (GALOIS) begin
        fb = r[LFSR_WIDTH-1] ^ b;
        r  = {r[LFSR_WIDTH-2:0], 1'b0};
        if (fb) r = r ^ LFSR_POLY;
      end else begin
        fb = b ^ (^(r & LFSR_POLY));
        r  = {r[LFSR_WIDTH-2:0], fb};
      end
    end
    return r;
  endfunction

  logic [LFSR_WIDTH-1:0] chain [KEEP_WIDTH+1];

  assign chain[0] = state_i;

  for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_lane
    assign chain[k+1] = byte_step(chain[k], data_i[8*k +: 8]);
  end

  // Count of contiguous enabled lanes from byte 0.
  always_comb begin
    logic run;
    n_o = '0;
    run = 1'b1;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (!keep_i[i]) run = 1'b0;
      if (run) n_o = NW'(i + 1);
    end
  end

  // Select the step covering exactly n_o bytes.
  always_comb begin
    step_o = state_i;
    for (int i = 1; i <= KEEP_WIDTH; i++) begin
      if (n_o == NW'(i)) step_o = chain[i];
    end
  end

endmodule

// File: rtl/lfsr_crc_stream.sv
// lfsr_crc_stream: streaming per-frame CRC with held result.
// Define LFSR_CRC_STREAM_CHECK_EN to build the residue checker.
module lfsr_crc_stream
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = LFSR_WIDTH'(CRC32_POLY),
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = '1,
  parameter string                 LFSR_CONFIG = "GALOIS",
  parameter bit                    REVERSE     = 1'b1,
  parameter bit                    INVERT      = 1'b1,
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int                    LEN_WIDTH   = 16,
  parameter logic [LFSR_WIDTH-1:0] RESIDUE     = LFSR_WIDTH'(CRC32_RESIDUE)
) (
  input logic              clk,
  input logic              rst,
  lfsr_crc_stream_if.slave bus
);

  localparam int NW = $clog2(KEEP_WIDTH + 1);
  localparam int SW = ((LEN_WIDTH > NW) ? LEN_WIDTH : NW) + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] step;
  logic [LFSR_WIDTH-1:0] raw;
  logic [LFSR_WIDTH-1:0] crc_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [LEN_WIDTH-1:0]  cnt_d;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [NW-1:0]         n;
  logic [SW-1:0]         sum;
  logic                  ok_q;
  logic                  ok_d;
  logic                  valid_q;
  logic                  accept;
  frame_state_e          fsm_q;

  lfsr_crc_stream_lanes #(
    .LFSR_WIDTH  (LFSR_WIDTH),
    .LFSR_POLY   (LFSR_POLY),
    .LFSR_CONFIG (LFSR_CONFIG),
    .REVERSE     (REVERSE),
    .DATA_WIDTH  (DATA_WIDTH),
    .KEEP_WIDTH  (KEEP_WIDTH),
    .NW          (NW)
  ) u_lanes (
    .state_i (state_q),
    .data_i  (bus.s_data),
    .keep_i  (bus.s_keep),
    .step_o  (step),
    .n_o     (n)
  );

  function automatic logic [LFSR_WIDTH-1:0] bitrev(
    input logic [LFSR_WIDTH-1:0] v
  );
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  assign raw    = REVERSE ? bitrev(step) : step;
  assign sum    = SW'(cnt_q) + SW'(n);
  assign cnt_d  = (sum > SW'(LEN_MAX)) ? LEN_MAX : sum[LEN_WIDTH-1:0];
  assign accept = bus.s_valid && bus.s_ready;

`ifdef LFSR_CRC_STREAM_CHECK_EN
  assign ok_d = (raw == RESIDUE);
`else
  logic unused_residue;
  assign unused_residue = ^RESIDUE;
  assign ok_d = 1'b0;
`endif

  assign bus.s_ready  = !valid_q || bus.m_ready;
  assign bus.m_crc    = crc_q;
  assign bus.m_len    = len_q;
  assign bus.m_crc_ok = ok_q;
  assign bus.m_valid  = valid_q;

  // LFSR state, byte count and held frame result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_INIT;
      cnt_q   <= '0;
      crc_q   <= '0;
      len_q   <= '0;
      ok_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && bus.m_ready) valid_q <= 1'b0;
      if (accept) begin
        if (bus.s_last) begin
          state_q <= LFSR_INIT;
          cnt_q   <= '0;
          crc_q   <= INVERT ? ~raw : raw;
          len_q   <= cnt_d;
          ok_q    <= ok_d;
          valid_q <= 1'b1;
        end else begin
          state_q <= step;
          cnt_q   <= cnt_d;
        end
      end
    end
  end

  // Frame delimiting status: idle versus mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= FRM_IDLE;
    end else if (accept) begin
      unique case (fsm_q)
        FRM_IDLE: if (!bus.s_last) fsm_q <= FRM_IN;
        FRM_IN:   if (bus.s_last) fsm_q <= FRM_IDLE;
        default:  fsm_q <= FRM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_crc_stream.sv
// tb_lfsr_crc_stream: directed stream with result scoreboard.
// Reference CRC is the bytewise reflected CRC-32 algorithm.
module tb_lfsr_crc_stream;

  typedef struct {
    logic [31:0] crc;
    logic [15:0] len;
    logic        ok;
  } exp_t;

`ifdef LFSR_CRC_STREAM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  exp_t       sb [$];
  exp_t       last_exp;
  logic [7:0] fbq [$];
  logic [15:0] mlen = '0;

  always #5 clk = ~clk;

  lfsr_crc_stream_if #(
    .DATA_WIDTH (32), .LFSR_WIDTH (32), .LEN_WIDTH (16)
  ) bus ();

  lfsr_crc_stream_if #(
    .DATA_WIDTH (32), .LFSR_WIDTH (32), .LEN_WIDTH (4)
  ) bus4 ();

  lfsr_crc_stream #(
    .LFSR_WIDTH (32), .DATA_WIDTH (32), .LEN_WIDTH (16)
  ) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  lfsr_crc_stream #(
    .LFSR_WIDTH (32), .DATA_WIDTH (32), .LEN_WIDTH (4)
  ) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_reg(input logic [7:0] q [$]);
    logic [31:0] c;
    c = 32'hffffffff;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic drive(
    input logic [31:0] d,
    input logic [3:0]  k,
    input logic        l
  );
    logic run;
    logic [31:0] r;
    exp_t e;
    bus.s_data  = d;
    bus.s_keep  = k;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!k[i]) run = 1'b0;
      if (run) begin
        fbq.push_back(d[8*i +: 8]);
        if (mlen != 16'hffff) mlen = mlen + 16'd1;
      end
    end
    if (l) begin
      r     = crc_reg(fbq);
      e.crc = ~r;
      e.len = mlen;
      e.ok  = CHK && (r == 32'hdebb20e3);
      sb.push_back(e);
      last_exp = e;
      fbq.delete();
      mlen = '0;
    end
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept", {31'h0, bus.s_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic beat(
    input logic [31:0] d,
    input logic [3:0]  k,
    input logic        l
  );
    drive(d, k, l);
    wait_accept();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    fbq.delete();
    mlen = '0;
  endtask

  // Scoreboard: every consumed result is popped and compared.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      chk("sb_nonempty", {31'h0, sb.size() != 0}, 32'h1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_crc", bus.m_crc, e.crc);
        chk("sb_len", {16'h0, bus.m_len}, {16'h0, e.len});
        chk("sb_ok", {31'h0, bus.m_crc_ok}, {31'h0, e.ok});
      end
    end
  end

  initial begin
    logic [7:0]  q4 [$];
    logic [31:0] w;
    exp_t ea;
    bus.s_data   = '0;
    bus.s_keep   = '0;
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
    bus.m_ready  = 1'b1;
    bus4.s_data  = '0;
    bus4.s_keep  = '0;
    bus4.s_valid = 1'b0;
    bus4.s_last  = 1'b0;
    bus4.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_valid", {31'h0, bus.m_valid}, 32'h0);
    chk("rst_crc", bus.m_crc, 32'h0);
    chk("rst_len", {16'h0, bus.m_len}, 32'h0);
    chk("rst_ok", {31'h0, bus.m_crc_ok}, 32'h0);
    chk("rst_ready", {31'h0, bus.s_ready}, 32'h1);

    // "123456789" check value
    beat(32'h34333231, 4'hf, 1'b0);
    beat(32'h38373635, 4'hf, 1'b0);
    beat(32'h00000039, 4'h1, 1'b1);
    chk("std_valid", {31'h0, bus.m_valid}, 32'h1);
    chk("std_crc", bus.m_crc, 32'hcbf43926);
    chk("std_len", {16'h0, bus.m_len}, 32'd9);

    // Data plus FCS: residue check
    beat(32'h34333231, 4'hf, 1'b0);
    beat(32'h38373635, 4'hf, 1'b0);
    beat(32'hf4392639, 4'hf, 1'b0);
    beat(32'h000000cb, 4'h1, 1'b1);
    chk("fcs_ok", {31'h0, bus.m_crc_ok}, {31'h0, CHK});
    chk("fcs_len", {16'h0, bus.m_len}, 32'd13);

    // Same with one data bit flipped
    beat(32'h34333230, 4'hf, 1'b0);
    beat(32'h38373635, 4'hf, 1'b0);
    beat(32'hf4392639, 4'hf, 1'b0);
    beat(32'h000000cb, 4'h1, 1'b1);
    chk("flip_ok", {31'h0, bus.m_crc_ok}, 32'h0);

    // Result held while m_ready is low
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    beat(32'hdeadbeef, 4'hf, 1'b1);
    ea = last_exp;
    drive(32'h11223344, 4'hf, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", {31'h0, bus.s_ready}, 32'h0);
      chk("stall_valid", {31'h0, bus.m_valid}, 32'h1);
      chk("stall_crc", bus.m_crc, ea.crc);
    end
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("drain_valid", {31'h0, bus.m_valid}, 32'h1);
    chk("drain_crc", bus.m_crc, last_exp.crc);

    // Back-to-back one-beat frames
    for (int i = 0; i < 6; i++) begin
      beat($urandom, 4'hf, 1'b1);
      chk("b2b_valid", {31'h0, bus.m_valid}, 32'h1);
      chk("b2b_crc", bus.m_crc, last_exp.crc);
    end

    // Zero-length and non-contiguous keep
    beat(32'h0, 4'h0, 1'b1);
    chk("zero_crc", bus.m_crc, 32'h0);
    chk("zero_len", {16'h0, bus.m_len}, 32'h0);
    beat(32'h44332231, 4'b1101, 1'b1);
    chk("keep_len", {16'h0, bus.m_len}, 32'd1);

    // Reset discards pending result and partial frame
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    beat(32'h55aa55aa, 4'hf, 1'b1);
    pulse_rst();
    chk("rst_mid_valid", {31'h0, bus.m_valid}, 32'h0);
    beat(32'h11111111, 4'hf, 1'b0);
    pulse_rst();
    chk("rst_frame_valid", {31'h0, bus.m_valid}, 32'h0);
    bus.m_ready = 1'b1;
    beat(32'h34333231, 4'hf, 1'b0);
    beat(32'h38373635, 4'hf, 1'b0);
    beat(32'h00000039, 4'h1, 1'b1);
    chk("post_rst_crc", bus.m_crc, 32'hcbf43926);
    chk("post_rst_len", {16'h0, bus.m_len}, 32'd9);

    // Saturating 4-bit length on a 20-byte frame
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) begin
        w[8*j +: 8] = 8'(8'h41 + 8'(4*b + j));
        q4.push_back(w[8*j +: 8]);
      end
      bus4.s_data  = w;
      bus4.s_keep  = 4'hf;
      bus4.s_last  = (b == 4);
      bus4.s_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus4.s_valid = 1'b0;
    bus4.s_last  = 1'b0;
    chk("sat_valid", {31'h0, bus4.m_valid}, 32'h1);
    chk("sat_len", {28'h0, bus4.m_len}, 32'd15);
    chk("sat_crc", bus4.m_crc, ~crc_reg(q4));

    repeat (4) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
